// File: rtl/cond_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cond_issue_ctrl                                            |
// | Description : Conditional-execution issue controller. Owns the status    |
// |               register, tracks outstanding flag-setting instructions,    |
// |               gates the ID->EX handshake and evaluates ARM condition     |
// |               codes into a registered execute-enable.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cond_issue_ctrl #(
  parameter int MAX_PEND = 4,
  parameter bit BYPASS   = 1'b1,
  localparam int PW      = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [3:0]    issue_cond,
  input  logic          issue_s,
  output logic          issue_ready,
  input  logic          flag_wr_valid,
  input  logic [3:0]    flag_wr,
  output logic          ex_valid,
  output logic          ex_exec,
  output logic [3:0]    sr,
  output logic [PW-1:0] pend_cnt,
  output logic          err
);

  localparam logic [3:0]    COND_AL    = 4'b1110;
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PEND);
  localparam logic [PW-1:0] PEND_ONE   = PW'(1);
  localparam logic [PW-1:0] PEND_ZERO  = '0;

  logic       byp_hit;
  logic [3:0] eval_flags;
  logic       needs_flags;
  logic       flags_final;
  logic       pass;
  logic       fire;
  logic       inc;
  logic       dec;

  // Flags packed {z,c,n,v}; evaluates one ARM condition code.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Handshake and condition evaluation; the last outstanding flags may be
  // forwarded in the cycle they return so a dependent instruction needn't wait.
  always_comb begin
    byp_hit     = BYPASS && (pend_cnt == PEND_ONE) && flag_wr_valid;
    eval_flags  = byp_hit ? flag_wr : sr;
    needs_flags = (issue_cond != COND_AL);
    flags_final = (pend_cnt == PEND_ZERO) | byp_hit;
    pass        = cond_pass(issue_cond, eval_flags);
    issue_ready = ~rst & (~needs_flags | flags_final)
                & ~(issue_s & pass & (pend_cnt == PEND_MAX));
    fire        = issue_valid & issue_ready;
    inc         = fire & pass & issue_s;
    dec         = flag_wr_valid & (pend_cnt != PEND_ZERO);
  end

  // Execute stage pulses, status register, outstanding count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_exec  <= 1'b0;
      sr       <= 4'b0000;
      pend_cnt <= PEND_ZERO;
      err      <= 1'b0;
    end else begin
      ex_valid <= fire;
      ex_exec  <= fire & pass;
      if (dec) begin
        sr <= flag_wr;
      end
      if (inc && !dec) begin
        pend_cnt <= pend_cnt + PEND_ONE;
      end else if (dec && !inc) begin
        pend_cnt <= pend_cnt - PEND_ONE;
      end
      if (flag_wr_valid && (pend_cnt == PEND_ZERO)) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
